// File: rtl/bus_timer_slave.sv
// 32-bit interval timer bus slave: CTRL/INTR/EXPIRE/COUNTER registers, level irq, one-wait-state registered reads.
// Optional macro TIMER_PRESCALER_EN adds CTRL[15:8] prescale so one tick is generated every PSC+1 cycles.
module bus_timer_slave #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cs_i,
  input  logic              as_i,
  input  logic              rw_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic              rdy_o,
  output logic              irq_o
);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_INTR   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_EXPIRE = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(3);

  logic              start_q, start_d;
  logic              periodic_q, periodic_d;
  logic              flag_q, flag_d;
  logic [WORD_W-1:0] expire_q, expire_d;
  logic [WORD_W-1:0] count_q, count_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic              rdy_q, rdy_d;

  logic              access, wr_en, rd_en, ctrl_wr, tick, expire_ev;
  logic [WORD_W-1:0] ctrl_val, rd_val;

  assign access    = cs_i & as_i;
  assign wr_en     = access & ~rw_i;
  assign rd_en     = access & rw_i;
  assign ctrl_wr   = wr_en && (addr_i == A_CTRL);
  assign expire_ev = tick && (count_q == expire_q);

`ifdef TIMER_PRESCALER_EN
  logic [7:0] psc_q, psc_d, pre_q, pre_d;

  assign tick  = start_q && (pre_q == psc_q);
  assign psc_d = ctrl_wr ? wr_data_i[15:8] : psc_q;
  // Prescale phase restarts whenever the timer is stopped or reprogrammed.
  assign pre_d = (!start_q || ctrl_wr || tick) ? 8'd0 : pre_q + 8'd1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      psc_q <= 8'd0;
      pre_q <= 8'd0;
    end else begin
      psc_q <= psc_d;
      pre_q <= pre_d;
    end
  end
`else
  assign tick = start_q;
`endif

  always_comb begin
    ctrl_val    = '0;
    ctrl_val[0] = start_q;
    ctrl_val[1] = periodic_q;
`ifdef TIMER_PRESCALER_EN
    ctrl_val[15:8] = psc_q;
`endif
    rd_val = '0;
    case (addr_i)
      A_CTRL:   rd_val = ctrl_val;
      A_INTR:   rd_val[0] = flag_q;
      A_EXPIRE: rd_val = expire_q;
      A_COUNT:  rd_val = count_q;
    endcase
  end

  always_comb begin
    start_d    = start_q;
    periodic_d = periodic_q;
    flag_d     = flag_q;
    expire_d   = expire_q;
    count_d    = count_q;
    rdy_d      = access;
    rd_data_d  = rd_en ? rd_val : '0;

    if (tick) count_d = expire_ev ? '0 : count_q + WORD_W'(1);
    if (expire_ev && !periodic_q) start_d = 1'b0;
    if (wr_en && addr_i == A_INTR && wr_data_i[0]) flag_d = 1'b0;
    if (expire_ev) flag_d = 1'b1;

    // Bus writes are applied last so they override timer-side updates.
    if (ctrl_wr) begin
      start_d    = wr_data_i[0];
      periodic_d = wr_data_i[1];
    end
    if (wr_en && addr_i == A_EXPIRE) expire_d = wr_data_i;
    if (wr_en && addr_i == A_COUNT)  count_d  = wr_data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      start_q    <= 1'b0;
      periodic_q <= 1'b0;
      flag_q     <= 1'b0;
      expire_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rdy_q      <= 1'b0;
    end else begin
      start_q    <= start_d;
      periodic_q <= periodic_d;
      flag_q     <= flag_d;
      expire_q   <= expire_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rdy_q      <= rdy_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign rdy_o     = rdy_q;
  assign irq_o     = flag_q;

endmodule

// File: tb/tb_bus_timer_slave.sv
// Directed bench for bus_timer_slave; expected values are hand-derived cycle by cycle.
module tb_bus_timer_slave;
  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        cs_i, as_i, rw_i;
  logic [1:0]  addr_i;
  logic [31:0] wr_data_i;
  logic [31:0] rd_data_o;
  logic        rdy_o, irq_o;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] CTRL = 2'd0, INTR = 2'd1, EXPIRE = 2'd2, COUNT = 2'd3;

  bus_timer_slave #(.WORD_W(32), .ADDR_W(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .cs_i(cs_i), .as_i(as_i), .rw_i(rw_i),
    .addr_i(addr_i), .wr_data_i(wr_data_i), .rd_data_o(rd_data_o),
    .rdy_o(rdy_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic acc(input logic r, input logic [1:0] a, input logic [31:0] d, output logic [31:0] q);
    cs_i = 1'b1; as_i = 1'b1; rw_i = r; addr_i = a; wr_data_i = d;
    @(posedge clk_i);
    #1;
    cs_i = 1'b0; as_i = 1'b0; rw_i = 1'b0;
    chk("rdy", {31'b0, rdy_o}, 32'd1);
    q = rd_data_o;
    if (!r) chk("wr_rd_data", rd_data_o, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] q;
    acc(1'b0, a, d, q);
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] q;
    acc(1'b1, a, 32'd0, q);
    chk(tag, q, exp);
  endtask

  initial begin
    logic [31:0] q;
    reset_i = 1'b1; cs_i = 1'b0; as_i = 1'b0; rw_i = 1'b0; addr_i = 2'd0; wr_data_i = 32'd0;
    cyc(2);
    chk("rst_rdy", {31'b0, rdy_o}, 32'd0);
    chk("rst_rd_data", rd_data_o, 32'd0);
    chk("rst_irq", {31'b0, irq_o}, 32'd0);
    reset_i = 1'b0;
    cyc(1);
    rd("rst_ctrl", CTRL, 32'd0);
    rd("rst_intr", INTR, 32'd0);
    rd("rst_expire", EXPIRE, 32'd0);
    rd("rst_count", COUNT, 32'd0);
    cyc(1);
    chk("idle_rdy", {31'b0, rdy_o}, 32'd0);
    chk("idle_rd_data", rd_data_o, 32'd0);

    // One-shot: irq rises 6 edges after the CTRL write edge.
    wr(EXPIRE, 32'd5);
    wr(CTRL, 32'h1);
    cyc(5);
    chk("oneshot_irq_pre", {31'b0, irq_o}, 32'd0);
    cyc(1);
    chk("oneshot_irq", {31'b0, irq_o}, 32'd1);
    rd("oneshot_ctrl", CTRL, 32'd0);
    rd("oneshot_count", COUNT, 32'd0);
    cyc(3);
    rd("oneshot_count_hold", COUNT, 32'd0);
    rd("intr_flag", INTR, 32'd1);
    wr(INTR, 32'd0);
    chk("intr_wr0_irq", {31'b0, irq_o}, 32'd1);
    wr(INTR, 32'd1);
    chk("intr_clr_irq", {31'b0, irq_o}, 32'd0);

    // Periodic, EXPIRE=3: events at E4, E8, E12.
    wr(EXPIRE, 32'd3);
    wr(CTRL, 32'h3);
    cyc(4);
    chk("per_irq_e4", {31'b0, irq_o}, 32'd1);
    wr(INTR, 32'd1);
    chk("per_clr_e5", {31'b0, irq_o}, 32'd0);
    cyc(2);
    chk("per_irq_e7", {31'b0, irq_o}, 32'd0);
    cyc(1);
    chk("per_irq_e8", {31'b0, irq_o}, 32'd1);
    cyc(3);
    wr(INTR, 32'd1);
    chk("per_clr_vs_set", {31'b0, irq_o}, 32'd1);
    rd("per_count_e13", COUNT, 32'd0);
    wr(CTRL, 32'h0);
    wr(INTR, 32'd1);
    chk("per_stop_irq", {31'b0, irq_o}, 32'd0);

    // Wrap through 0xFFFF_FFFF.
    wr(COUNT, 32'hFFFF_FFFE);
    wr(EXPIRE, 32'd2);
    wr(CTRL, 32'h1);
    rd("wrap_0", COUNT, 32'hFFFF_FFFE);
    rd("wrap_1", COUNT, 32'hFFFF_FFFF);
    rd("wrap_2", COUNT, 32'h0);
    rd("wrap_3", COUNT, 32'h1);
    rd("wrap_4", COUNT, 32'h2);
    rd("wrap_5", COUNT, 32'h0);
    chk("wrap_irq", {31'b0, irq_o}, 32'd1);
    wr(INTR, 32'd1);

    // Back-to-back accesses, then strobe without chip select.
    wr(CTRL, 32'h2);
    wr(EXPIRE, 32'h10);
    rd("b2b_expire", EXPIRE, 32'h10);
    rd("b2b_ctrl", CTRL, 32'h2);
    cyc(1);
    chk("b2b_rdy_drop", {31'b0, rdy_o}, 32'd0);
    chk("b2b_rd_idle", rd_data_o, 32'd0);
    cs_i = 1'b0; as_i = 1'b1; rw_i = 1'b0; addr_i = EXPIRE; wr_data_i = 32'h55;
    cyc(1);
    as_i = 1'b0;
    chk("nocs_rdy", {31'b0, rdy_o}, 32'd0);
    rd("nocs_expire", EXPIRE, 32'h10);

    // EXPIRE=0: event every tick; collisions with INTR and COUNTER writes.
    wr(EXPIRE, 32'd0);
    wr(CTRL, 32'h3);
    wr(INTR, 32'd1);
    chk("exp0_clr_vs_set", {31'b0, irq_o}, 32'd1);
    wr(COUNT, 32'd7);
    rd("exp0_bus_wins", COUNT, 32'd7);
    wr(CTRL, 32'h0);
    wr(INTR, 32'd1);
    chk("exp0_clr", {31'b0, irq_o}, 32'd0);
    wr(COUNT, 32'd0);
    wr(CTRL, 32'h1);
    wr(CTRL, 32'h3);
    rd("ctrl_wr_vs_oneshot", CTRL, 32'h3);
    wr(CTRL, 32'h0);
    wr(INTR, 32'd1);
    chk("ctrl_coll_clr", {31'b0, irq_o}, 32'd0);

`ifdef TIMER_PRESCALER_EN
    // PSC=3: count steps at E4, E8; event at E12.
    wr(EXPIRE, 32'd2);
    wr(COUNT, 32'd0);
    wr(CTRL, 32'h0301);
    cyc(4);
    rd("psc_count_e5", COUNT, 32'd1);
    cyc(6);
    chk("psc_irq_e11", {31'b0, irq_o}, 32'd0);
    cyc(1);
    chk("psc_irq_e12", {31'b0, irq_o}, 32'd1);
    rd("psc_ctrl", CTRL, 32'h0300);
    wr(CTRL, 32'h0);
    wr(INTR, 32'd1);
`else
    wr(CTRL, 32'hFF02);
    rd("psc_ignored", CTRL, 32'h2);
    wr(CTRL, 32'h0);
`endif

    // Reset in the middle of counting with irq and rdy high.
    wr(EXPIRE, 32'd0);
    wr(CTRL, 32'h1);
    wr(EXPIRE, 32'h100);
    wr(CTRL, 32'h1);
    cyc(1);
    acc(1'b1, COUNT, 32'd0, q);
    chk("midrst_count", q, 32'd1);
    chk("midrst_irq_pre", {31'b0, irq_o}, 32'd1);
    reset_i = 1'b1;
    #1;
    chk("midrst_rdy", {31'b0, rdy_o}, 32'd0);
    chk("midrst_rd_data", rd_data_o, 32'd0);
    chk("midrst_irq", {31'b0, irq_o}, 32'd0);
    cyc(2);
    reset_i = 1'b0;
    rd("postrst_count", COUNT, 32'd0);
    rd("postrst_ctrl", CTRL, 32'd0);
    rd("postrst_expire", EXPIRE, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
